// File: rtl/pkt_dmux_mc.sv
// ---------------------------------------------------------------------------
// pkt_dmux_mc
// Packet distributor: routes every received packet to any subset of N_CH
// downstream channels, selected by a destination bitmask carried in the
// header beat. Admission per channel is decided once, at the header, from the
// downstream almost-full flags, so a packet is either delivered whole to a
// channel or not at all. Output beat and valids are registered (1-cycle
// latency); the beat register is shared by all channels.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_data_valid       input beat valid (one beat accepted per valid cycle)
//   i_data             input beat; [DATA_W-1:DATA_W-2] is the tag
//   i_alf              per-channel almost-full from downstream
//   i_cnt_clr          synchronous clear of all statistics counters
//   o_data_valid       per-channel registered output valid
//   o_data             registered output beat (holds when no valid input)
//   o_alf              advisory backpressure to upstream (OR / AND of i_alf)
//   o_fwd_cnt          per-channel forwarded-packet counters, packed
//   o_drop_cnt         per-channel dropped-packet counters, packed
//   o_err_cnt          protocol-error counter
// ---------------------------------------------------------------------------
module pkt_dmux_mc #(
  parameter int DATA_W  = 134,
  parameter int N_CH    = 3,
  parameter int DST_LSB = 28,
  parameter int CNT_W   = 16,
  parameter int ALF_ALL = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_data_valid,
  input  logic [DATA_W-1:0]        i_data,
  input  logic [N_CH-1:0]          i_alf,
  input  logic                     i_cnt_clr,
  output logic [N_CH-1:0]          o_data_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_alf,
  output logic [N_CH*CNT_W-1:0]    o_fwd_cnt,
  output logic [N_CH*CNT_W-1:0]    o_drop_cnt,
  output logic [CNT_W-1:0]         o_err_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FWD  = 1'b1
  } state_t;

  localparam logic [1:0] TAG_HEAD = 2'b11;
  localparam logic [1:0] TAG_BODY = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;
  localparam logic [1:0] TAG_ILL  = 2'b00;

  // Saturating increment: an all-ones counter stays put instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t              state_q, state_d;
  logic [N_CH-1:0]     mask_q, mask_d;
  logic [N_CH-1:0]     valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    fwd_cnt_q  [N_CH];
  logic [CNT_W-1:0]    fwd_cnt_d  [N_CH];
  logic [CNT_W-1:0]    drop_cnt_q [N_CH];
  logic [CNT_W-1:0]    drop_cnt_d [N_CH];
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic [1:0]          tag_s;
  logic [N_CH-1:0]     hdr_mask_s;
  logic [N_CH-1:0]     adm_mask_s;
  logic                is_head_s;
  logic                is_data_s;
  logic                is_tail_s;
  logic                err_s;
  logic [N_CH-1:0]     fwd_inc_s;
  logic [N_CH-1:0]     drop_inc_s;

  // Beat decode; only the N_CH bits at DST_LSB form the destination mask.
  always_comb begin
    tag_s      = i_data[DATA_W-1 -: 2];
    hdr_mask_s = i_data[DST_LSB +: N_CH];
    adm_mask_s = hdr_mask_s & ~i_alf;
    is_head_s  = i_data_valid && (tag_s == TAG_HEAD);
    is_data_s  = i_data_valid && ((tag_s == TAG_BODY) || (tag_s == TAG_TAIL));
    is_tail_s  = i_data_valid && (tag_s == TAG_TAIL);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a head always (re)starts a packet, even from FWD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (is_head_s) begin
          state_d = ST_FWD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FWD: begin
        if (is_head_s) begin
          state_d = ST_FWD;
        end else if (is_tail_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FWD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath decisions for the current beat.
  always_comb begin
    mask_d     = mask_q;
    valid_d    = '0;
    err_s      = 1'b0;
    fwd_inc_s  = '0;
    drop_inc_s = '0;
    data_d     = i_data_valid ? i_data : data_q;
    if (is_head_s) begin
      // Admission decided here only; later i_alf changes do not matter.
      mask_d     = adm_mask_s;
      valid_d    = adm_mask_s;
      fwd_inc_s  = adm_mask_s;
      drop_inc_s = hdr_mask_s & i_alf;
      err_s      = (state_q == ST_FWD);
    end else if (is_data_s) begin
      if (state_q == ST_FWD) begin
        valid_d = mask_q;
      end else begin
        err_s = 1'b1;
      end
    end else if (i_data_valid) begin
      // Tag 00: discarded regardless of state.
      err_s = 1'b1;
    end else begin
      valid_d = '0;
    end
  end

  // Counter next values; clear overrides any same-cycle increment.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      fwd_cnt_d[k]  = fwd_cnt_q[k];
      drop_cnt_d[k] = drop_cnt_q[k];
      if (i_cnt_clr) begin
        fwd_cnt_d[k]  = '0;
        drop_cnt_d[k] = '0;
      end else begin
        if (fwd_inc_s[k]) begin
          fwd_cnt_d[k] = sat_inc(fwd_cnt_q[k]);
        end else begin
          fwd_cnt_d[k] = fwd_cnt_q[k];
        end
        if (drop_inc_s[k]) begin
          drop_cnt_d[k] = sat_inc(drop_cnt_q[k]);
        end else begin
          drop_cnt_d[k] = drop_cnt_q[k];
        end
      end
    end
    if (i_cnt_clr) begin
      err_cnt_d = '0;
    end else if (err_s) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Datapath and statistics registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask_q    <= '0;
      valid_q   <= '0;
      data_q    <= '0;
      err_cnt_q <= '0;
      for (int k = 0; k < N_CH; k++) begin
        fwd_cnt_q[k]  <= '0;
        drop_cnt_q[k] <= '0;
      end
    end else begin
      mask_q    <= mask_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      err_cnt_q <= err_cnt_d;
      for (int k = 0; k < N_CH; k++) begin
        fwd_cnt_q[k]  <= fwd_cnt_d[k];
        drop_cnt_q[k] <= drop_cnt_d[k];
      end
    end
  end

  // Upstream backpressure; forced low while reset is asserted.
  always_comb begin
    if (!i_rst_n) begin
      o_alf = 1'b0;
    end else if (ALF_ALL != 0) begin
      o_alf = &i_alf;
    end else begin
      o_alf = |i_alf;
    end
  end

  assign o_data_valid = valid_q;
  assign o_data       = data_q;
  assign o_err_cnt    = err_cnt_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign o_fwd_cnt[g*CNT_W +: CNT_W]  = fwd_cnt_q[g];
    assign o_drop_cnt[g*CNT_W +: CNT_W] = drop_cnt_q[g];
  end

endmodule

// File: tb/tb_pkt_dmux_mc.sv
module tb_pkt_dmux_mc;
  localparam int DATA_W  = 134;
  localparam int N_CH    = 3;
  localparam int DST_LSB = 28;
  localparam int CNT_W   = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic [N_CH-1:0]       in_alf;
  logic                  cnt_clr;
  logic [N_CH-1:0]       out_valid;
  logic [DATA_W-1:0]     out_data;
  logic                  out_alf;
  logic [N_CH*CNT_W-1:0] fwd_cnt;
  logic [N_CH*CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0]      err_cnt;
  // Second instance only used to observe o_alf in AND mode.
  logic [N_CH-1:0]       out_valid_b;
  logic [DATA_W-1:0]     out_data_b;
  logic                  out_alf_b;
  logic [N_CH*CNT_W-1:0] fwd_cnt_b;
  logic [N_CH*CNT_W-1:0] drop_cnt_b;
  logic [CNT_W-1:0]      err_cnt_b;

  pkt_dmux_mc #(.DATA_W(DATA_W), .N_CH(N_CH), .DST_LSB(DST_LSB), .CNT_W(CNT_W), .ALF_ALL(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_valid(in_valid), .i_data(in_data),
    .i_alf(in_alf), .i_cnt_clr(cnt_clr), .o_data_valid(out_valid), .o_data(out_data),
    .o_alf(out_alf), .o_fwd_cnt(fwd_cnt), .o_drop_cnt(drop_cnt), .o_err_cnt(err_cnt));

  pkt_dmux_mc #(.DATA_W(DATA_W), .N_CH(N_CH), .DST_LSB(DST_LSB), .CNT_W(CNT_W), .ALF_ALL(1)) dut_and (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_valid(in_valid), .i_data(in_data),
    .i_alf(in_alf), .i_cnt_clr(cnt_clr), .o_data_valid(out_valid_b), .o_data(out_data_b),
    .o_alf(out_alf_b), .o_fwd_cnt(fwd_cnt_b), .o_drop_cnt(drop_cnt_b), .o_err_cnt(err_cnt_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  typedef struct packed {
    logic [N_CH-1:0]   v;
    logic [DATA_W-1:0] d;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state.
  logic              m_fwd_st;
  logic [N_CH-1:0]   m_mask;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  m_fwd [N_CH];
  logic [CNT_W-1:0]  m_drop[N_CH];
  logic [CNT_W-1:0]  m_err;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [CNT_W-1:0] sinc(input logic [CNT_W-1:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  function automatic logic [DATA_W-1:0] mk(input logic [1:0] tag, input logic [N_CH-1:0] msk);
    logic [DATA_W-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom, $urandom};
    d[DATA_W-1 -: 2] = tag;
    d[DST_LSB +: N_CH] = msk;
    return d;
  endfunction

  task automatic model_reset();
    m_fwd_st = 1'b0;
    m_mask   = '0;
    m_data   = '0;
    m_err    = '0;
    for (int k = 0; k < N_CH; k++) begin
      m_fwd[k]  = '0;
      m_drop[k] = '0;
    end
    exp_q.delete();
  endtask

  // Drive one cycle, update model, push expectation, then compare output.
  task automatic beat(input logic v, input logic [DATA_W-1:0] d, input logic [N_CH-1:0] alf,
                      input logic clr);
    exp_t e;
    exp_t got;
    logic [1:0] tg;
    logic [N_CH-1:0] hm;
    in_valid = v; in_data = d; in_alf = alf; cnt_clr = clr;
    tg = d[DATA_W-1 -: 2];
    hm = d[DST_LSB +: N_CH];
    e.v = '0;
    if (v) begin
      if (tg == 2'b00) begin
        m_err = sinc(m_err);
      end else if (tg == 2'b11) begin
        if (m_fwd_st) m_err = sinc(m_err);
        for (int k = 0; k < N_CH; k++) begin
          if (hm[k] && alf[k]) m_drop[k] = sinc(m_drop[k]);
          if (hm[k] && !alf[k]) m_fwd[k] = sinc(m_fwd[k]);
        end
        m_mask = hm & ~alf;
        m_fwd_st = 1'b1;
        e.v = m_mask;
      end else if (!m_fwd_st) begin
        m_err = sinc(m_err);
      end else begin
        e.v = m_mask;
        if (tg == 2'b10) m_fwd_st = 1'b0;
      end
      m_data = d;
    end
    if (clr) begin
      m_err = '0;
      for (int k = 0; k < N_CH; k++) begin
        m_fwd[k]  = '0;
        m_drop[k] = '0;
      end
    end
    e.d = m_data;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 160'd1, 160'd0);
    end else begin
      got = exp_q.pop_front();
      chk("o_data_valid", {157'd0, out_valid}, {157'd0, got.v});
      chk("o_data", {26'd0, out_data}, {26'd0, got.d});
    end
    in_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic check_cnts(input string tag);
    for (int k = 0; k < N_CH; k++) begin
      chk({tag, "_fwd"},  {156'd0, fwd_cnt[k*CNT_W +: CNT_W]},  {156'd0, m_fwd[k]});
      chk({tag, "_drop"}, {156'd0, drop_cnt[k*CNT_W +: CNT_W]}, {156'd0, m_drop[k]});
    end
    chk({tag, "_err"}, {156'd0, err_cnt}, {156'd0, m_err});
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_alf = 3'b101; cnt_clr = 1'b0;
    model_reset();
    #22;
    // Reset state: all outputs zero, o_alf not following i_alf.
    chk("rst_valid", {157'd0, out_valid}, 160'd0);
    chk("rst_data", {26'd0, out_data}, 160'd0);
    chk("rst_alf", {159'd0, out_alf}, 160'd0);
    chk("rst_alf_and", {159'd0, out_alf_b}, 160'd0);
    check_cnts("rst");
    rst_n = 1'b1;
    in_alf = '0;
    @(posedge clk); #1;

    // Unicast to channel 1.
    beat(1'b1, mk(2'b11, 3'b010), 3'b000, 1'b0);
    beat(1'b1, mk(2'b01, 3'b000), 3'b000, 1'b0);
    beat(1'b1, mk(2'b01, 3'b000), 3'b000, 1'b0);
    beat(1'b1, mk(2'b10, 3'b000), 3'b000, 1'b0);
    beat(1'b0, mk(2'b01, 3'b000), 3'b000, 1'b0);
    check_cnts("uni");

    // Multicast with partial drop; alf change mid-packet is ignored.
    beat(1'b1, mk(2'b11, 3'b111), 3'b100, 1'b0);
    beat(1'b1, mk(2'b01, 3'b000), 3'b001, 1'b0);
    beat(1'b0, mk(2'b01, 3'b000), 3'b001, 1'b0);
    beat(1'b1, mk(2'b10, 3'b000), 3'b001, 1'b0);
    check_cnts("mcast");

    // Full drop, then a normal packet.
    beat(1'b1, mk(2'b11, 3'b001), 3'b001, 1'b0);
    beat(1'b1, mk(2'b01, 3'b000), 3'b000, 1'b0);
    beat(1'b1, mk(2'b10, 3'b000), 3'b000, 1'b0);
    beat(1'b1, mk(2'b11, 3'b001), 3'b000, 1'b0);
    beat(1'b1, mk(2'b10, 3'b000), 3'b000, 1'b0);
    check_cnts("drop");

    // Protocol errors: body in IDLE, head in FWD, tag 00 in FWD and IDLE.
    beat(1'b1, mk(2'b01, 3'b111), 3'b000, 1'b0);
    beat(1'b1, mk(2'b11, 3'b001), 3'b000, 1'b0);
    beat(1'b1, mk(2'b01, 3'b000), 3'b000, 1'b0);
    beat(1'b1, mk(2'b11, 3'b100), 3'b000, 1'b0);
    beat(1'b1, mk(2'b00, 3'b111), 3'b000, 1'b0);
    beat(1'b1, mk(2'b10, 3'b000), 3'b000, 1'b0);
    beat(1'b1, mk(2'b00, 3'b111), 3'b000, 1'b0);
    check_cnts("err");

    // Saturation: 17 packets to channel 0 after a clear.
    beat(1'b0, mk(2'b00, 3'b000), 3'b000, 1'b1);
    for (int i = 0; i < 17; i++) begin
      beat(1'b1, mk(2'b11, 3'b001), 3'b000, 1'b0);
      beat(1'b1, mk(2'b10, 3'b000), 3'b000, 1'b0);
    end
    check_cnts("sat");
    chk("sat_fwd0_F", {156'd0, fwd_cnt[3:0]}, 160'hF);
    beat(1'b1, mk(2'b11, 3'b011), 3'b000, 1'b1);
    check_cnts("clr");
    chk("clr_fwd0_0", {156'd0, fwd_cnt[3:0]}, 160'd0);
    beat(1'b1, mk(2'b10, 3'b000), 3'b000, 1'b0);

    // Asynchronous reset mid-packet.
    beat(1'b1, mk(2'b11, 3'b110), 3'b000, 1'b0);
    beat(1'b1, mk(2'b01, 3'b000), 3'b000, 1'b0);
    in_alf = 3'b111;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", {157'd0, out_valid}, 160'd0);
    chk("arst_data", {26'd0, out_data}, 160'd0);
    chk("arst_alf", {159'd0, out_alf}, 160'd0);
    check_cnts("arst");
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    beat(1'b1, mk(2'b01, 3'b000), 3'b000, 1'b0);
    beat(1'b1, mk(2'b10, 3'b000), 3'b000, 1'b0);
    check_cnts("post_rst");
    chk("post_rst_err2", {156'd0, err_cnt}, 160'd2);

    // o_alf modes.
    in_alf = 3'b010; #1;
    chk("alf_or_010", {159'd0, out_alf}, 160'd1);
    chk("alf_and_010", {159'd0, out_alf_b}, 160'd0);
    in_alf = 3'b111; #1;
    chk("alf_and_111", {159'd0, out_alf_b}, 160'd1);
    in_alf = 3'b000; #1;
    chk("alf_or_000", {159'd0, out_alf}, 160'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
